// File: rtl/cevero_dvfs_ctrl.sv
// Closed-loop DVFS controller: windowed error counting from several sources steps the
// operating level up/down through a req/ack regulator handshake followed by a settle interval.
module cevero_dvfs_ctrl #(
    parameter int unsigned NumErr       = 2,
    parameter int unsigned LevelW       = 3,
    parameter int unsigned MinLevel     = 0,
    parameter int unsigned MaxLevel     = 5,
    parameter int unsigned DefLevel     = 3,
    parameter int unsigned WindowLen    = 16,
    parameter int unsigned ErrThresh    = 3,
    parameter int unsigned OkWindows    = 10,
    parameter int unsigned SettleCycles = 8,
    parameter int unsigned CntW         = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [NumErr-1:0] error_i,
    input  logic              force_valid_i,
    input  logic [LevelW-1:0] force_level_i,
    input  logic              vreg_ack_i,
    output logic              vreg_req_o,
    output logic [LevelW-1:0] vreg_level_o,
    output logic [LevelW-1:0] level_o,
    output logic              busy_o,
    output logic              step_up_o,
    output logic              step_dn_o
);

    localparam int unsigned TimerW = (WindowLen > 1) ? $clog2(WindowLen) : 1;
    localparam int unsigned OkW    = $clog2(OkWindows + 1);
    localparam int unsigned SetW   = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    localparam logic [LevelW-1:0] MinL = LevelW'(MinLevel);
    localparam logic [LevelW-1:0] MaxL = LevelW'(MaxLevel);
    localparam logic [LevelW-1:0] DefL = LevelW'(DefLevel);

    typedef enum logic [1:0] {ST_COUNT, ST_EVAL, ST_REQ, ST_SETTLE} state_e;

    state_e              state_q, state_d;
    logic [LevelW-1:0]   level_q, level_d;
    logic [LevelW-1:0]   target_q, target_d;
    logic [LevelW-1:0]   vreg_level_q, vreg_level_d;
    logic                vreg_req_q, vreg_req_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [CntW-1:0]     err_acc_q, err_acc_d;
    logic [OkW-1:0]      ok_cnt_q, ok_cnt_d;
    logic [SetW-1:0]     settle_q, settle_d;
    logic                step_up_q, step_up_d;
    logic                step_dn_q, step_dn_d;

    logic [CntW:0]       pop, acc_sum;
    logic [CntW-1:0]     acc_sat;
    logic [OkW-1:0]      ok_inc;
    logic [LevelW-1:0]   up_tgt, dn_tgt, force_tgt, tgt;
    logic                launch;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_COUNT;
            level_q      <= DefL;
            target_q     <= DefL;
            vreg_level_q <= DefL;
            vreg_req_q   <= 1'b0;
            timer_q      <= '0;
            err_acc_q    <= '0;
            ok_cnt_q     <= '0;
            settle_q     <= '0;
            step_up_q    <= 1'b0;
            step_dn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            target_q     <= target_d;
            vreg_level_q <= vreg_level_d;
            vreg_req_q   <= vreg_req_d;
            timer_q      <= timer_d;
            err_acc_q    <= err_acc_d;
            ok_cnt_q     <= ok_cnt_d;
            settle_q     <= settle_d;
            step_up_q    <= step_up_d;
            step_dn_q    <= step_dn_d;
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NumErr; i++) begin
            pop = pop + (CntW+1)'(error_i[i]);
        end
        acc_sum = {1'b0, err_acc_q} + pop;
        acc_sat = acc_sum[CntW] ? '1 : acc_sum[CntW-1:0];
        ok_inc  = (ok_cnt_q == '1) ? ok_cnt_q : ok_cnt_q + OkW'(1);
        up_tgt  = (level_q >= MaxL) ? MaxL : level_q + LevelW'(1);
        dn_tgt  = (level_q <= MinL) ? MinL : level_q - LevelW'(1);
        if (32'(force_level_i) < MinLevel) begin
            force_tgt = MinL;
        end else if (32'(force_level_i) > MaxLevel) begin
            force_tgt = MaxL;
        end else begin
            force_tgt = force_level_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        target_d     = target_q;
        vreg_level_d = vreg_level_q;
        vreg_req_d   = vreg_req_q;
        timer_d      = timer_q;
        err_acc_d    = err_acc_q;
        ok_cnt_d     = ok_cnt_q;
        settle_d     = settle_q;
        step_up_d    = 1'b0;
        step_dn_d    = 1'b0;
        launch       = 1'b0;
        tgt          = level_q;

        unique case (state_q)
            ST_COUNT: begin
                if (force_valid_i) begin
                    launch    = 1'b1;
                    tgt       = force_tgt;
                    timer_d   = '0;
                    err_acc_d = '0;
                    ok_cnt_d  = '0;
                end else if (en_i) begin
                    err_acc_d = acc_sat;
                    if (timer_q == TimerW'(WindowLen - 1)) begin
                        timer_d = '0;
                        state_d = ST_EVAL;
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end else begin
                    timer_d   = '0;
                    err_acc_d = '0;
                end
            end
            ST_EVAL: begin
                launch    = 1'b1;
                err_acc_d = '0;
                if (force_valid_i) begin
                    tgt      = force_tgt;
                    timer_d  = '0;
                    ok_cnt_d = '0;
                end else if (err_acc_q > CntW'(ErrThresh)) begin
                    tgt      = up_tgt;
                    ok_cnt_d = '0;
                end else if (err_acc_q == '0) begin
                    if (ok_inc >= OkW'(OkWindows)) begin
                        tgt      = dn_tgt;
                        ok_cnt_d = '0;
                    end else begin
                        ok_cnt_d = ok_inc;
                    end
                end else begin
                    ok_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (vreg_ack_i) begin
                    level_d    = target_q;
                    vreg_req_d = 1'b0;
                    step_up_d  = (target_q > level_q);
                    step_dn_d  = (target_q < level_q);
                    settle_d   = '0;
                    timer_d    = '0;
                    err_acc_d  = '0;
                    state_d    = (SettleCycles == 0) ? ST_COUNT : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SetW'(SettleCycles - 1)) begin
                    timer_d   = '0;
                    err_acc_d = '0;
                    state_d   = ST_COUNT;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            default: state_d = ST_COUNT;
        endcase

        // COUNT-force and EVAL share one launch path: request only on a real level change.
        if (launch) begin
            if (tgt != level_q) begin
                state_d      = ST_REQ;
                target_d     = tgt;
                vreg_req_d   = 1'b1;
                vreg_level_d = tgt;
            end else begin
                state_d = ST_COUNT;
            end
        end
    end

    always_comb begin
        busy_o       = (state_q == ST_REQ) || (state_q == ST_SETTLE);
        vreg_req_o   = vreg_req_q;
        vreg_level_o = vreg_level_q;
        level_o      = level_q;
        step_up_o    = step_up_q;
        step_dn_o    = step_dn_q;
    end

endmodule
